// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory interface: controller state encoding,
// memory geometry and the load/store opcodes the control unit decodes.
package mem_if_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2,
        StErr    = 2'd3
    } mem_state_e;

    localparam int unsigned DMEM_ADDR_W = 10;
    localparam int unsigned DMEM_WORDS  = 1024;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Wait-counter width; a zero-latency memory still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory-latency counter: cleared when a command is accepted, incremented while the
// strobe is held, flags terminal count when it reaches WAIT_CYCLES.
module mem_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller of the multicycle CPU: issues one load/store to the
// word-addressed data memory, waits out its latency and captures read data into LMD.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic [31:0]       i_addr,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_lmd,
    output logic              o_mem_r,
    output logic              o_mem_w,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

    mem_state_e        r_state, w_state_d;
    logic              r_is_load, w_is_load_d;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_d;
    logic [DATA_W-1:0] r_lmd, w_lmd_d;
    logic              r_busy, r_done, r_err, r_mem_r, r_mem_w;
    logic              w_cmd_ok, w_cnt_clear, w_cnt_inc, w_cnt_tc;

    // Exactly one access kind, and the word address must fit the memory.
    assign w_cmd_ok = (i_is_load ^ i_is_store) && (i_addr[31:ADDR_W] == '0);

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_wait_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .o_tc    (w_cnt_tc)
    );

    always_comb begin
        w_state_d     = r_state;
        w_is_load_d   = r_is_load;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_lmd_d       = r_lmd;
        w_cnt_clear   = 1'b0;
        w_cnt_inc     = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    if (w_cmd_ok) begin
                        w_state_d     = StAccess;
                        w_is_load_d   = i_is_load;
                        w_mem_addr_d  = i_addr[ADDR_W-1:0];
                        w_mem_wdata_d = i_store_data;
                        w_cnt_clear   = 1'b1;
                    end else begin
                        w_state_d = StErr;
                    end
                end else begin
                    w_state_d = StIdle;
                end
            end
            StAccess: begin
                if (w_cnt_tc) begin
                    if (r_is_load) begin
                        w_lmd_d = i_mem_rdata;
                    end
                    w_state_d = StDone;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change only on clock edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_is_load   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_lmd       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_r     <= 1'b0;
            r_mem_w     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_is_load   <= w_is_load_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_lmd       <= w_lmd_d;
            r_busy      <= (w_state_d == StAccess) || (w_state_d == StErr);
            r_done      <= (w_state_d == StDone) || (w_state_d == StErr);
            r_err       <= (w_state_d == StErr);
            r_mem_r     <= (w_state_d == StAccess) && w_is_load_d;
            r_mem_w     <= (w_state_d == StAccess) && !w_is_load_d;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_lmd       = r_lmd;
    assign o_mem_r     = r_mem_r;
    assign o_mem_w     = r_mem_w;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl paired with a behavioural 1024-word memory preloaded mem[k]=k*3.
module tb_mem_access_ctrl;

    localparam int unsigned W = 1;

    logic        clk, rst, start, is_load, is_store;
    logic [31:0] addr, store_data;
    logic        busy, done, err, mem_r, mem_w;
    logic [31:0] lmd, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic        preload;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] m_lmd;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        err;
        logic [31:0] lmd;
        int          done_cyc;
        int          nr;
        int          nw;
        logic [9:0]  addr;
        logic        valid;
    } exp_t;
    exp_t q[$];

    mem_access_ctrl #(
        .ADDR_W      (10),
        .DATA_W      (32),
        .WAIT_CYCLES (W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_is_load    (is_load),
        .i_is_store   (is_store),
        .i_addr       (addr),
        .i_store_data (store_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_lmd        (lmd),
        .o_mem_r      (mem_r),
        .o_mem_w      (mem_w),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'(k * 3);
        end else if (mem_w) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or on timeout).
    task automatic exec(input logic l, input logic s, input logic [31:0] a,
                        input logic [31:0] d, input logic noise);
        exp_t e;
        int nr, nw, both, done_c;
        logic got_err, busy1, first;
        logic [31:0] got_lmd;
        logic [9:0] got_addr;
        e.valid = (l ^ s) && (a[31:10] == 22'd0);
        e.err = !e.valid;
        if (e.valid && l) m_lmd = ref_mem[a[9:0]];
        if (e.valid && s) ref_mem[a[9:0]] = d;
        e.lmd      = m_lmd;
        e.done_cyc = e.valid ? int'(W) + 2 : 1;
        e.nr       = (e.valid && l) ? int'(W) + 1 : 0;
        e.nw       = (e.valid && s) ? int'(W) + 1 : 0;
        e.addr     = a[9:0];
        q.push_back(e);

        start = 1'b1; is_load = l; is_store = s; addr = a; store_data = d;
        @(negedge clk);
        start = 1'b0;
        nr = 0; nw = 0; both = 0; done_c = -1; first = 1'b1;
        got_err = 1'bx; got_lmd = 'x; got_addr = 'x; busy1 = 1'bx;
        for (int c = 1; c <= 30; c++) begin
            if (c == 1) busy1 = busy;
            if (mem_r) nr++;
            if (mem_w) nw++;
            if (mem_r && mem_w) both++;
            if ((mem_r || mem_w) && first) begin
                got_addr = mem_addr;
                first = 1'b0;
            end
            if (done) begin
                done_c = c; got_err = err; got_lmd = lmd;
                break;
            end
            if (noise && c <= int'(W)) begin
                start = 1'b1; is_load = 1'b0; is_store = 1'b1;
                addr = 32'd7; store_data = 32'h1234_5678;
            end else begin
                start = 1'b0; is_load = 1'b0; is_store = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;

        e = q.pop_front();
        chk("done_cycle", 32'(done_c), 32'(e.done_cyc));
        chk("err", 32'(got_err), 32'(e.err));
        chk("lmd", got_lmd, e.lmd);
        chk("mem_r_cycles", 32'(nr), 32'(e.nr));
        chk("mem_w_cycles", 32'(nw), 32'(e.nw));
        chk("strobe_overlap", 32'(both), 32'd0);
        chk("busy_first", 32'(busy1), 32'd1);
        if (e.valid) chk("mem_addr", 32'(got_addr), 32'(e.addr));
    endtask

    task automatic count_dones(input int cycles, input string tag);
        int nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk(tag, 32'(nd), 32'd0);
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        addr = '0; store_data = '0;
        for (int k = 0; k < 1024; k++) ref_mem[k] = 32'(k * 3);
        m_lmd = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_lmd", lmd, 32'd0);
        chk("rst_strobes", 32'({mem_r, mem_w}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0; preload = 1'b0;
        @(negedge clk);

        exec(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
        @(negedge clk);
        exec(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        exec(1'b1, 1'b0, 32'd7, 32'd0, 1'b0);
        @(negedge clk);
        exec(1'b1, 1'b0, 32'h400, 32'd0, 1'b0);
        @(negedge clk);
        exec(1'b1, 1'b1, 32'd3, 32'd0, 1'b0);
        @(negedge clk);
        exec(1'b0, 1'b0, 32'd3, 32'd0, 1'b0);
        @(negedge clk);
        exec(1'b1, 1'b0, 32'd2, 32'd0, 1'b1);
        count_dones(4, "extra_done");

        // Second start lands in the DONE cycle of the store.
        exec(1'b0, 1'b1, 32'd1, 32'd9, 1'b0);
        exec(1'b1, 1'b0, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        exec(1'b0, 1'b1, 32'd1023, 32'hA5A5_0001, 1'b0);
        exec(1'b1, 1'b0, 32'd1023, 32'd0, 1'b0);
        @(negedge clk);

        start = 1'b1; is_load = 1'b1; is_store = 1'b0; addr = 32'd4;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0;
        chk("pre_rst_mem_r", 32'(mem_r), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_strobes", 32'({mem_r, mem_w}), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_lmd", lmd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_lmd = '0;
        count_dones(4, "post_rst_done");
        exec(1'b1, 1'b0, 32'd10, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
